blk_lock_extract: RTL and testbench



---
 rtl/blk_lock_extract_pkg.sv | 26 ++
 rtl/blk_lock_extract_descrambler.sv | 44 ++++
 rtl/blk_lock_extract.sv | 178 +++++++++++++++++
 tb/tb_blk_lock_extract.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_lock_extract_pkg.sv
// Shared types and constants for the Aurora 64b/66b block lock/extract slice.
package blk_lock_extract_pkg;

    localparam int unsigned BLK_W     = 66;
    localparam int unsigned PAY_W     = 64;
    localparam int unsigned BUF_W     = 194;
    localparam int unsigned POS_W     = 7;
    localparam int unsigned SCR_W     = 58;
    localparam int unsigned SCR_TAP_A = 38;
    localparam int unsigned SCR_TAP_B = 57;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // A sync header is legal only when its two bits differ.
    function automatic logic hdr_is_ok(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/blk_lock_extract_descrambler.sv
// Self-synchronous x^58+x^39+1 descrambler, 64 bits per enable, bit 0 first.
// Ports: clk_i/rst_ni clock and async reset; en_i advance state; clr_i zero
// state (has priority); data_i scrambled payload; data_o_c descrambled
// payload (combinational from data_i and current state).
module aurora_descrambler
    import blk_lock_extract_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PAY_W-1:0] data_i,
    output logic [PAY_W-1:0] data_o_c
);

    logic [SCR_W-1:0] scr_q;
    logic [SCR_W-1:0] scr_d;
    logic [SCR_W-1:0] hist;

    // History holds the scrambled bits; newest bit sits at index 0.
    always_comb begin
        data_o_c = '0;
        hist     = scr_q;
        for (int i = 0; i < int'(PAY_W); i++) begin
            data_o_c[i] = data_i[i] ^ hist[SCR_TAP_A] ^ hist[SCR_TAP_B];
            hist        = {hist[SCR_W-2:0], data_i[i]};
        end
        scr_d = scr_q;
        if (clr_i) begin
            scr_d = '0;
        end else if (en_i) begin
            scr_d = hist;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scr_q <= '0;
        end else begin
            scr_q <= scr_d;
        end
    end

endmodule

// File: rtl/blk_lock_extract.sv
// Block lock qualifier and 66-bit block extractor behind the header seeker.
// Ports: clk_i/rst_ni clock and async active-low reset; gbox_buffer/gbox_cnt/
// buffer_dv gearbox window; is_synced/offset_pos seeker result; blk_valid,
// blk_hdr, blk_data, blk_hdr_err extracted block; locked, lock_pos,
// lock_loss_cnt lock status.
module blk_lock_extract
    import blk_lock_extract_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_ERR = 16,
    parameter int unsigned ERR_WIN    = 64,
    parameter bit          DESCRAMBLE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [BUF_W-1:0] gbox_buffer,
    input  logic [5:0]       gbox_cnt,
    input  logic             buffer_dv,
    input  logic             is_synced,
    input  logic [POS_W-1:0] offset_pos,
    output logic             blk_valid,
    output logic [1:0]       blk_hdr,
    output logic [PAY_W-1:0] blk_data,
    output logic             blk_hdr_err,
    output logic             locked,
    output logic [POS_W-1:0] lock_pos,
    output logic [7:0]       lock_loss_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned ERR_W  = $clog2(UNLOCK_ERR + 1);
    localparam int unsigned WIN_W  = $clog2(ERR_WIN + 1);

    lock_state_e      state_q, state_d;
    logic [POS_W-1:0] lock_pos_q, lock_pos_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [ERR_W-1:0] err_q, err_d, err_base, err_inc;
    logic [WIN_W-1:0] win_q, win_d;
    logic [7:0]       loss_q, loss_d;
    logic             valid_q, valid_d;
    logic [1:0]       hdr_q, hdr_d;
    logic [PAY_W-1:0] data_q, data_d;
    logic             herr_q, herr_d;
    logic             locked_q, locked_d;

    logic             blk_avail_c;
    logic [BLK_W-1:0] blk_c;
    logic             hdr_ok_c;
    logic             scr_clr_c;
    logic [PAY_W-1:0] pay_out_c;
    logic             unused_gbox_c;

    // Only even gearbox windows carry a fresh block.
    assign blk_avail_c   = buffer_dv & ~gbox_cnt[0];
    assign unused_gbox_c = ^gbox_cnt[5:1];
    assign blk_c         = BLK_W'(gbox_buffer >> lock_pos_q);
    assign hdr_ok_c      = hdr_is_ok(blk_c[BLK_W-1:PAY_W]);

    // Descrambler runs in every state so it is primed before LOCKED.
    if (DESCRAMBLE) begin : g_descr
        aurora_descrambler u_descr (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (blk_avail_c),
            .clr_i    (scr_clr_c),
            .data_i   (blk_c[PAY_W-1:0]),
            .data_o_c (pay_out_c)
        );
    end else begin : g_raw
        logic unused_scr_clr;
        assign unused_scr_clr = scr_clr_c;
        assign pay_out_c      = blk_c[PAY_W-1:0];
    end

    // Lock state machine, error window and output capture.
    always_comb begin
        state_d    = state_q;
        lock_pos_d = lock_pos_q;
        good_d     = good_q;
        err_d      = err_q;
        win_d      = win_q;
        loss_d     = loss_q;
        valid_d    = 1'b0;
        hdr_d      = hdr_q;
        data_d     = data_q;
        herr_d     = herr_q;
        scr_clr_c  = 1'b0;
        err_base   = err_q;
        err_inc    = err_q + ERR_W'(1);

        if (blk_avail_c) begin
            unique case (state_q)
                HUNT: begin
                    if (is_synced) begin
                        lock_pos_d = offset_pos;
                        good_d     = '0;
                        scr_clr_c  = 1'b1;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!hdr_ok_c) begin
                        state_d = HUNT;
                    end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                        err_d   = '0;
                        win_d   = '0;
                        state_d = LOCKED;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    valid_d = 1'b1;
                    hdr_d   = blk_c[BLK_W-1:PAY_W];
                    data_d  = pay_out_c;
                    herr_d  = ~hdr_ok_c;
                    if (win_q == WIN_W'(ERR_WIN - 1)) begin
                        win_d    = '0;
                        err_base = '0;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                    end
                    // An error on the wrap cycle counts into the fresh window.
                    err_inc = err_base + ERR_W'(1);
                    err_d   = err_base;
                    if (!hdr_ok_c) begin
                        err_d = err_inc;
                        if (err_inc == ERR_W'(UNLOCK_ERR)) begin
                            state_d = HUNT;
                            if (loss_q != 8'hFF) begin
                                loss_d = loss_q + 8'd1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HUNT;
            lock_pos_q <= '0;
            good_q     <= '0;
            err_q      <= '0;
            win_q      <= '0;
            loss_q     <= '0;
            valid_q    <= 1'b0;
            hdr_q      <= '0;
            data_q     <= '0;
            herr_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_pos_q <= lock_pos_d;
            good_q     <= good_d;
            err_q      <= err_d;
            win_q      <= win_d;
            loss_q     <= loss_d;
            valid_q    <= valid_d;
            hdr_q      <= hdr_d;
            data_q     <= data_d;
            herr_q     <= herr_d;
            locked_q   <= locked_d;
        end
    end

    assign blk_valid     = valid_q;
    assign blk_hdr       = hdr_q;
    assign blk_data      = data_q;
    assign blk_hdr_err   = herr_q;
    assign locked        = locked_q;
    assign lock_pos      = lock_pos_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_blk_lock_extract.sv
// Directed bench: one raw (DESCRAMBLE=0) and one descrambling instance share
// the same scrambled block stream placed at bit offset 17.
module tb_blk_lock_extract;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [193:0] gbox_buffer;
    logic [5:0]   gbox_cnt;
    logic         buffer_dv;
    logic         is_synced;
    logic [6:0]   offset_pos;

    logic        r_valid, d_valid, r_herr, d_herr, r_locked, d_locked;
    logic [1:0]  r_hdr, d_hdr;
    logic [63:0] r_data, d_data;
    logic [6:0]  r_lpos, d_lpos;
    logic [7:0]  r_loss, d_loss;

    always #5 clk_i = ~clk_i;

    blk_lock_extract #(.DESCRAMBLE(1'b0)) u_raw (
        .clk_i(clk_i), .rst_ni(rst_ni), .gbox_buffer(gbox_buffer),
        .gbox_cnt(gbox_cnt), .buffer_dv(buffer_dv), .is_synced(is_synced),
        .offset_pos(offset_pos), .blk_valid(r_valid), .blk_hdr(r_hdr),
        .blk_data(r_data), .blk_hdr_err(r_herr), .locked(r_locked),
        .lock_pos(r_lpos), .lock_loss_cnt(r_loss));

    blk_lock_extract #(.DESCRAMBLE(1'b1)) u_dsc (
        .clk_i(clk_i), .rst_ni(rst_ni), .gbox_buffer(gbox_buffer),
        .gbox_cnt(gbox_cnt), .buffer_dv(buffer_dv), .is_synced(is_synced),
        .offset_pos(offset_pos), .blk_valid(d_valid), .blk_hdr(d_hdr),
        .blk_data(d_data), .blk_hdr_err(d_herr), .locked(d_locked),
        .lock_pos(d_lpos), .lock_loss_cnt(d_loss));

    typedef struct {
        logic       sync;
        logic [6:0] off;
        logic       bad;
        logic       ev;
        logic       el;
        logic       eh;
        logic [7:0] eloss;
    } vec_t;

    vec_t        tbl [0:511];
    int          n_vec = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hdr_sel = 0;
    logic [57:0] sc;
    logic [63:0] plain_v;
    logic [1:0]  last_hdr;
    logic [63:0] last_scr;
    logic [1:0]  hold_hdr;
    logic [63:0] hold_raw, hold_dsc;
    logic        hold_herr;

    task automatic add(input logic sync, input logic [6:0] off, input logic bad,
                       input logic ev, input logic el, input logic eh,
                       input logic [7:0] eloss);
        tbl[n_vec] = '{sync, off, bad, ev, el, eh, eloss};
        n_vec++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [193:0] rand_buf();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[193:0];
    endfunction

    // Scramble the plaintext (seeded all-ones at start) and present one block at offset 17.
    task automatic send(input logic sync, input logic [6:0] off, input logic bad);
        logic [63:0] c;
        logic        cb;
        logic [1:0]  hdr;
        for (int i = 0; i < 64; i++) begin
            cb   = plain_v[i] ^ sc[38] ^ sc[57];
            c[i] = cb;
            sc   = {sc[56:0], cb};
        end
        if (bad) hdr = hdr_sel[0] ? 2'b11 : 2'b00;
        else     hdr = hdr_sel[0] ? 2'b10 : 2'b01;
        hdr_sel++;
        gbox_buffer          = rand_buf();
        gbox_buffer[17 +: 66] = {hdr, c};
        buffer_dv  = 1'b1;
        gbox_cnt   = {5'($urandom), 1'b0};
        is_synced  = sync;
        offset_pos = off;
        last_hdr   = hdr;
        last_scr   = c;
        @(negedge clk_i);
    endtask

    // Non-block cycle: must not change anything, outputs must hold.
    task automatic idle(input int i);
        gbox_buffer = rand_buf();
        is_synced   = 1'b1;
        offset_pos  = 7'($urandom_range(0, 65));
        if (i % 2 == 0) begin
            buffer_dv = 1'b1;
            gbox_cnt  = {5'($urandom), 1'b1};
        end else begin
            buffer_dv = 1'b0;
            gbox_cnt  = {5'($urandom), 1'b0};
        end
        @(negedge clk_i);
        chk("idle_valid_raw", 64'(r_valid), 64'd0);
        chk("idle_valid_dsc", 64'(d_valid), 64'd0);
        chk("idle_hold_hdr", 64'(r_hdr), 64'(hold_hdr));
        chk("idle_hold_herr", 64'(d_herr), 64'(hold_herr));
        chk("idle_hold_raw", r_data, hold_raw);
        chk("idle_hold_dsc", d_data, hold_dsc);
    endtask

    task automatic check_outputs(input logic ev, input logic el, input logic eh,
                                 input logic [7:0] eloss, input logic [6:0] elp);
        chk("valid_raw", 64'(r_valid), 64'(ev));
        chk("valid_dsc", 64'(d_valid), 64'(ev));
        chk("locked_raw", 64'(r_locked), 64'(el));
        chk("locked_dsc", 64'(d_locked), 64'(el));
        chk("loss_cnt", 64'(r_loss), 64'(eloss));
        chk("loss_cnt_dsc", 64'(d_loss), 64'(eloss));
        chk("lock_pos", 64'(r_lpos), 64'(elp));
        chk("lock_pos_dsc", 64'(d_lpos), 64'(elp));
        if (ev) begin
            chk("blk_hdr", 64'(r_hdr), 64'(last_hdr));
            chk("blk_hdr_dsc", 64'(d_hdr), 64'(last_hdr));
            chk("hdr_err", 64'(r_herr), 64'(eh));
            chk("hdr_err_dsc", 64'(d_herr), 64'(eh));
            chk("data_raw", r_data, last_scr);
            chk("data_descr", d_data, plain_v);
            hold_hdr  = last_hdr;
            hold_herr = eh;
            hold_raw  = last_scr;
            hold_dsc  = plain_v;
        end
    endtask

    function automatic logic bad_at(input int k);
        return (k >= 2 && k <= 30 && (k % 2 == 0)) || (k >= 65 && k <= 79) ||
               (k >= 130 && k <= 143) || (k >= 191);
    endfunction

    initial begin
        plain_v     = 64'h0123_4567_89AB_CDEF;
        sc          = '1;
        rst_ni      = 1'b0;
        gbox_buffer = '0;
        gbox_cnt    = '0;
        buffer_dv   = 1'b0;
        is_synced   = 1'b0;
        offset_pos  = '0;
        hold_hdr    = '0;
        hold_herr   = 1'b0;
        hold_raw    = '0;
        hold_dsc    = '0;

        // Capture, 9 good, 00 header on block 10 -> HUNT.
        add(1, 17, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, 17, 0, 0, 0, 0, 0);
        add(1, 17, 1, 0, 0, 0, 0);
        // Recapture, 32 good headers -> LOCKED after the 32nd.
        add(1, 17, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) add(1, 17, 0, 0, 0, 0, 0);
        add(1, 17, 0, 0, 1, 0, 0);
        // Locked (offset_pos moved, must be ignored): 15 errs in w1, 15 in w2,
        // 14 in w3 plus one on the w3/w4 wrap, then 15 in w4 -> unlock on k=206.
        for (int k = 0; k <= 206; k++)
            add(1, 40, bad_at(k), 1, (k != 206), bad_at(k), (k == 206) ? 8'd1 : 8'd0);
        // Relock, then 16 errors in one window.
        add(1, 17, 0, 0, 0, 0, 1);
        for (int i = 0; i < 31; i++) add(1, 17, 0, 0, 0, 0, 1);
        add(1, 17, 0, 0, 1, 0, 1);
        for (int k = 0; k < 16; k++)
            add(1, 40, 1, 1, (k != 15), 1, (k == 15) ? 8'd2 : 8'd1);
        add(0, 17, 0, 0, 0, 0, 2);

        repeat (2) @(negedge clk_i);
        chk("rst_valid", 64'(r_valid), 64'd0);
        chk("rst_locked", 64'(d_locked), 64'd0);
        chk("rst_data", d_data, 64'd0);
        chk("rst_lock_pos", 64'(r_lpos), 64'd0);
        chk("rst_loss", 64'(r_loss), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < n_vec; i++) begin
            send(tbl[i].sync, tbl[i].off, tbl[i].bad);
            check_outputs(tbl[i].ev, tbl[i].el, tbl[i].eh, tbl[i].eloss, 7'd17);
            idle(i);
        end

        // Relock, then assert reset between clock edges.
        send(1, 17, 0);
        for (int i = 1; i <= 35; i++) begin
            send(1, 17, 0);
            check_outputs(i >= 33, i >= 32, 0, 8'd2, 7'd17);
        end
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(r_valid) | 64'(d_valid), 64'd0);
        chk("arst_locked", 64'(r_locked) | 64'(d_locked), 64'd0);
        chk("arst_hdr", 64'(r_hdr), 64'd0);
        chk("arst_herr", 64'(d_herr), 64'd0);
        chk("arst_data", r_data | d_data, 64'd0);
        chk("arst_lock_pos", 64'(d_lpos), 64'd0);
        chk("arst_loss", 64'(r_loss) | 64'(d_loss), 64'd0);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        hold_hdr = '0; hold_herr = 1'b0; hold_raw = '0; hold_dsc = '0;

        for (int i = 0; i < 5; i++) begin
            send(0, 17, 0);
            check_outputs(0, 0, 0, 8'd0, 7'd0);
            idle(i);
        end
        // First blk_valid after relock is on the 33rd block after capture.
        send(1, 17, 0);
        check_outputs(0, 0, 0, 8'd0, 7'd17);
        for (int i = 1; i <= 33; i++) begin
            send(1, 17, 0);
            check_outputs(i == 33, i >= 32, 0, 8'd0, 7'd17);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
